sound_mixer: RTL and testbench

Sums the per-voice 16-bit unsigned sound outputs (noise/explosion/shell voices, engine, POKEY) into one 16-bit audio sample stream for the audio output path. Sits directly downstream of the noise voices. Each voice is scaled by an 8-bit gain through one time-shared multiplier, then accumulated and saturated. A new sample is emitted at a fixed rate derived from the 3 MHz enable.

---
 rtl/mixer_pkg.sv | 25 ++
 rtl/mixer_mac.sv | 46 ++++
 rtl/sound_mixer.sv | 167 ++++++++++++++++
 tb/tb_sound_mixer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared constants, FSM state type and output saturation helper for the sound mixer.
package mixer_pkg;

    localparam int GAIN_SHIFT = 7;
    localparam int GAIN_UNITY = 128;
    // Widest accumulator the mixer can need (NUM_CH=8 -> 17+3 bits).
    localparam int ACC_MAX_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } mix_state_t;

    function automatic logic [15:0] sat16(input logic [ACC_MAX_W-1:0] acc);
        logic [15:0] res;
        if (|acc[ACC_MAX_W-1:16]) begin
            res = 16'hFFFF;
        end else begin
            res = acc[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mixer_mac.sv
// Single time-shared multiplier: scales one voice by its gain, drops the unity
// shift and accumulates the truncated term into a non-wrapping accumulator.
module mixer_mac
    import mixer_pkg::*;
#(
    parameter int GAIN_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add_en,
    input  logic [15:0]       sample,
    input  logic [GAIN_W-1:0] gain,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 16 + GAIN_W;
    localparam int TERM_W = PROD_W - GAIN_SHIFT;

    logic [PROD_W-1:0] product_s;
    logic [TERM_W-1:0] term_s;
    logic [ACC_W-1:0]  acc_r;

    // Scaled voice term, truncated per product before accumulation.
    always_comb begin
        product_s = PROD_W'(sample) * PROD_W'(gain);
        term_s    = product_s[PROD_W-1:GAIN_SHIFT];
    end

    // Accumulator with clear taking priority over add.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (add_en) begin
            acc_r <= acc_r + ACC_W'(term_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/sound_mixer.sv
// Mixes NUM_CH gain-scaled 16-bit voices into one saturated 16-bit sample,
// emitted once every SAMPLE_DIV pulses of the 3 MHz enable.
module sound_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 64,
    parameter int GAIN_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_3MHz_en,
    input  logic [NUM_CH*16-1:0]     ch_in,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic                     sound_enable,
    output logic [15:0]              out,
    output logic                     sample_strobe
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int ACC_W = 17 + IDX_W;

    logic [DIV_W-1:0]         div_r;
    mix_state_t               state_r;
    mix_state_t               state_nxt_s;
    logic [IDX_W-1:0]         idx_r;
    logic [NUM_CH*16-1:0]     snap_in_r;
    logic [NUM_CH*GAIN_W-1:0] snap_gain_r;
    logic                     snap_en_r;
    logic [15:0]              out_r;
    logic                     strobe_r;

    logic                     div_last_s;
    logic                     idx_last_s;
    logic                     snap_load_s;
    logic                     clr_s;
    logic                     add_s;
    logic                     emit_s;
    logic [15:0]              sel_in_s;
    logic [GAIN_W-1:0]        sel_gain_s;
    logic [ACC_W-1:0]         acc_s;

    assign div_last_s = (div_r == DIV_W'(SAMPLE_DIV - 1));
    assign idx_last_s = (idx_r == IDX_W'(NUM_CH - 1));

    // Voice currently being fed to the multiplier, taken only from the snapshot.
    always_comb begin
        sel_in_s   = snap_in_r[int'(idx_r)*16 +: 16];
        sel_gain_s = snap_gain_r[int'(idx_r)*GAIN_W +: GAIN_W];
    end

    // Sequencing: snapshot on the divider wrap, one voice per enable, then emit.
    always_comb begin
        state_nxt_s = state_r;
        snap_load_s = 1'b0;
        clr_s       = 1'b0;
        add_s       = 1'b0;
        emit_s      = 1'b0;
        if (clk_3MHz_en) begin
            case (state_r)
                IDLE: begin
                    if (div_last_s) begin
                        snap_load_s = 1'b1;
                        clr_s       = 1'b1;
                        state_nxt_s = ACC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACC: begin
                    add_s = 1'b1;
                    if (idx_last_s) begin
                        state_nxt_s = EMIT;
                    end else begin
                        state_nxt_s = ACC;
                    end
                end
                EMIT: begin
                    emit_s      = 1'b1;
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Free-running sample-rate divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (clk_3MHz_en) begin
            div_r <= div_last_s ? '0 : div_r + DIV_W'(1);
        end else begin
            div_r <= div_r;
        end
    end

    // FSM state and voice index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (snap_load_s) begin
                idx_r <= '0;
            end else if (add_s) begin
                idx_r <= idx_last_s ? '0 : idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Input snapshot; later input changes cannot disturb the sample in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_in_r   <= '0;
            snap_gain_r <= '0;
            snap_en_r   <= 1'b0;
        end else if (snap_load_s) begin
            snap_in_r   <= ch_in;
            snap_gain_r <= ch_gain;
            snap_en_r   <= sound_enable;
        end else begin
            snap_in_r   <= snap_in_r;
            snap_gain_r <= snap_gain_r;
            snap_en_r   <= snap_en_r;
        end
    end

    mixer_mac #(
        .GAIN_W (GAIN_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_s),
        .add_en (add_s),
        .sample (sel_in_s),
        .gain   (sel_gain_s),
        .acc    (acc_s)
    );

    // Output sample register and its update strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r    <= 16'h0000;
            strobe_r <= 1'b0;
        end else if (emit_s) begin
            out_r    <= snap_en_r ? sat16(ACC_MAX_W'(acc_s)) : 16'h0000;
            strobe_r <= 1'b1;
        end else begin
            out_r    <= out_r;
            strobe_r <= 1'b0;
        end
    end

    assign out           = out_r;
    assign sample_strobe = strobe_r;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed-vector bench for sound_mixer: pass-through, sum/truncation,
// saturation, master enable, snapshot isolation and reset mid-sample.
module tb_sound_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_3MHz_en;
    logic [63:0] ch_in;
    logic [31:0] ch_gain;
    logic        sound_enable;
    logic [15:0] out;
    logic        sample_strobe;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic strobe_now;
    logic gap_hit = 1'b0;
    int   n;

    sound_mixer #(
        .NUM_CH     (4),
        .SAMPLE_DIV (64),
        .GAIN_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_3MHz_en   (clk_3MHz_en),
        .ch_in         (ch_in),
        .ch_gain       (ch_gain),
        .sound_enable  (sound_enable),
        .out           (out),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    task automatic set_ch(input int i, input logic [15:0] val, input logic [7:0] g);
        ch_in[i*16 +: 16] = val;
        ch_gain[i*8 +: 8] = g;
    endtask

    // One enable pulse followed by one idle clk; strobe may never appear on the idle clk.
    task automatic pulse_en();
        @(negedge clk);
        clk_3MHz_en = 1'b1;
        @(posedge clk);
        #1 strobe_now = sample_strobe;
        @(negedge clk);
        clk_3MHz_en = 1'b0;
        @(posedge clk);
        #1 if (sample_strobe) gap_hit = 1'b1;
    endtask

    task automatic pulse_n(input int cnt);
        for (int k = 0; k < cnt; k++) pulse_en();
    endtask

    task automatic next_sample(output int cnt);
        logic got;
        got = 1'b0;
        cnt = 0;
        while (!got && cnt < 200) begin
            pulse_en();
            cnt++;
            got = strobe_now;
        end
        if (!got) check_val("strobe_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        clk_3MHz_en  = 1'b0;
        sound_enable = 1'b1;
        ch_in        = 64'd0;
        ch_gain      = 32'd0;
        set_ch(0, 16'h4000, 8'd128);
        repeat (3) @(negedge clk);
        check_val("reset_out", {16'd0, out}, 32'd0);
        check_val("reset_strobe", {31'd0, sample_strobe}, 32'd0);
        reset = 1'b0;

        // Unity pass-through and sample period
        next_sample(n);
        check_val("first_strobe_enables", n, 32'd69);
        check_val("unity_out", {16'd0, out}, 32'h4000);
        next_sample(n);
        check_val("period_enables", n, 32'd64);
        check_val("unity_out2", {16'd0, out}, 32'h4000);

        // Sum with per-product truncation
        set_ch(0, 16'd1000, 8'd64);
        set_ch(1, 16'd2000, 8'd64);
        set_ch(2, 16'd3000, 8'd64);
        set_ch(3, 16'd4000, 8'd64);
        next_sample(n);
        check_val("sum_out", {16'd0, out}, 32'd5000);

        set_ch(0, 16'd3, 8'd64);
        set_ch(1, 16'd0, 8'd0);
        set_ch(2, 16'd0, 8'd0);
        set_ch(3, 16'd0, 8'd0);
        next_sample(n);
        check_val("trunc_out", {16'd0, out}, 32'd1);

        // Saturation: 4 * 130558 exceeds 16 bits
        for (int i = 0; i < 4; i++) set_ch(i, 16'hFFFF, 8'd255);
        next_sample(n);
        check_val("sat_out", {16'd0, out}, 32'hFFFF);

        // Master enable low at snapshot, raised just after it
        set_ch(0, 16'd1000, 8'd64);
        set_ch(1, 16'd2000, 8'd64);
        set_ch(2, 16'd3000, 8'd64);
        set_ch(3, 16'd4000, 8'd64);
        sound_enable = 1'b0;
        pulse_n(59);
        sound_enable = 1'b1;
        next_sample(n);
        check_val("mute_latency", n, 32'd5);
        check_val("mute_out", {16'd0, out}, 32'd0);
        next_sample(n);
        check_val("unmute_out", {16'd0, out}, 32'd5000);

        // Snapshot isolation
        set_ch(0, 16'd1000, 8'd128);
        set_ch(1, 16'd0, 8'd0);
        set_ch(2, 16'd0, 8'd0);
        set_ch(3, 16'd0, 8'd0);
        pulse_n(59);
        set_ch(0, 16'd9000, 8'd128);
        next_sample(n);
        check_val("iso_latency", n, 32'd5);
        check_val("iso_old_out", {16'd0, out}, 32'd1000);
        next_sample(n);
        check_val("iso_new_out", {16'd0, out}, 32'd9000);

        // Reset for one clk at E0+2 discards the in-flight sample
        pulse_n(60);
        @(negedge clk);
        clk_3MHz_en = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        clk_3MHz_en = 1'b0;
        reset       = 1'b0;
        check_val("midacc_out", {16'd0, out}, 32'd0);
        check_val("midacc_strobe", {31'd0, sample_strobe}, 32'd0);
        next_sample(n);
        check_val("post_reset_enables", n, 32'd69);
        check_val("post_reset_out", {16'd0, out}, 32'd9000);

        check_val("strobe_off_enable", {31'd0, gap_hit}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
